fazyrv_rf_lut_gated: RTL and testbench
======================================

Name: fazyrv_rf_lut_gated

Overview:
- Next-generation logic-based register file for the chunked FazyRV datapath.
- Holds NR_REGS registers of XLEN bits as flop shift registers with asynchronous clear.
- Only the registers addressed by the current instruction (rs1, rs2, rd) rotate, for energy.
- A rotation FSM guarantees every access is a full word rotation, and an idle-time parallel debug port reads whole registers.

Parameters:
- CHUNKSIZE, 2, datapath chunk width; legal values 1, 2, 4, 8.
- NR_REGS, 32, number of architectural registers; legal values 16 (RVE) or 32.
- XLEN, 32, register width; must be divisible by CHUNKSIZE.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_in  in  1  asynchronous active-low reset.
- start_i  in  1  begin a rotation; latches the addresses.
- shft_i  in  1  advance one chunk.
- rs1_i  in  5  source address A.
- rs2_i  in  5  source address B.
- rd_i  in  5  destination address.
- we_i  in  1  write enable, sampled on each shift.
- res_i  in  CHUNKSIZE  write data chunk.
- ra_o  out  CHUNKSIZE  current chunk of register A.
- rb_o  out  CHUNKSIZE  current chunk of register B.
- busy_o  out  1  rotation in progress.
- done_o  out  1  one-cycle pulse when a rotation completes.
- dbg_req_i  in  1  debug read request.
- dbg_addr_i  in  5  debug read address.
- dbg_ack_o  out  1  debug read acknowledge.
- dbg_dat_o  out  XLEN  debug read data.

Behaviour:
- NCHUNK = XLEN/CHUNKSIZE. Chunk counter cnt is $clog2(NCHUNK) bits wide.
- Reset (asynchronous, any time including mid-rotation):
  - All registers clear to 0.
  - State returns to IDLE and cnt returns to 0.
  - Latched addresses clear to 0.
  - busy_o, done_o, dbg_ack_o and dbg_dat_o are 0.
- x0 and any address >= NR_REGS read as 0. Writes to them are dropped.
- Register storage is LSB-first. The low chunk of a register is its current output. A shift loads din into the top chunk and moves the rest down one chunk.
- din is res_i when (we_i and address == latched rd), otherwise the register's own low chunk.
- FSM state IDLE:
  - ra_o and rb_o show the low chunk of rs1_i and rs2_i (combinational).
  - start_i=1: latch rs1/rs2/rd, set cnt=0, go to ROT, busy_o=1 from the next cycle.
  - shft_i and we_i are ignored.
- FSM state ROT:
  - ra_o and rb_o follow the latched addresses.
  - On each shft_i=1, every distinct latched register shifts exactly once, even if rs1==rs2==rd, and cnt increments.
  - Shift at cnt==NCHUNK-1: cnt wraps to 0, state returns to IDLE, done_o=1 for the following cycle.
  - start_i during ROT is ignored.
  - shft_i=0 holds all state; no timeout.
- Non-addressed registers never shift, so every register is word-aligned whenever the FSM is in IDLE.
- Read-before-write: ra_o/rb_o at a shift show the pre-shift chunk, even when rs==rd.
- Debug port:
  - dbg_req_i is accepted only in IDLE with start_i=0; start_i has priority.
  - On accept, dbg_ack_o=1 and dbg_dat_o=word[dbg_addr_i] in the next cycle, one-cycle pulse.
  - A request not accepted is not acknowledged; the requester holds dbg_req_i.
  - dbg_dat_o holds its last value when dbg_ack_o=0.
- done_o and dbg_ack_o are never high in the same cycle.

Decomposition:
- Package fazyrv_rf_pkg holds:
  - the state enum rf_state_e {RF_IDLE, RF_ROT};
  - the NCHUNK-from-XLEN/CHUNKSIZE helper function;
  - the XLEN default constant.
- Sub-module fazyrv_rf_word: one XLEN register with shift enable, async clear, a chunk in/out port and a parallel read port.
  - Instantiated NR_REGS-1 times (x0 is omitted).

Test Plan:
- Reset clear: drive rst_in low for 2 cycles mid-rotation, release → busy_o=0 and dbg read of x5 returns 0x00000000.
- Write then read, CHUNKSIZE=2:
  - Rotation 1 (x0,x0→x3, we_i=1): res_i chunks encode 0xDEADBEEF, 16 shifts → done_o pulses after shift 16.
  - Rotation 2 (rs1=x3): ra_o sequence reproduces 0xDEADBEEF LSB-first: 3,3,2,3,…
- Self-modifying register: x7=0x00000001, then rs1=rs2=rd=x7, we_i=1, res_i = ra_o+1 chain →
  - ra_o and rb_o are identical every shift;
  - final x7=0x00000002;
  - x7 shifted exactly 16 times.
- Gating: preload x9=0x12345678, rotate on x1/x2/x4 only → debug read of x9 still 0x12345678, x9 internal shift count 0.
- RVE: NR_REGS=16, write rd=x20 with 0xFFFFFFFF → dbg read x20 = 0, rs1=x20 gives ra_o=0, x4 unchanged.
- Debug/start contention: assert dbg_req_i and start_i together in IDLE →
  - rotation starts, no dbg_ack_o;
  - with dbg_req_i held, ack arrives 1 cycle after done_o's cycle, with correct data.

Source files
------------

// File: rtl/fazyrv_rf_pkg.sv
// Shared types and helpers for the gated logic-based FazyRV register file.
package fazyrv_rf_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [0:0] {
    RF_IDLE = 1'b0,
    RF_ROT  = 1'b1
  } rf_state_e;

  function automatic int unsigned nchunk(input int unsigned xlen, input int unsigned chunksize);
    return xlen / chunksize;
  endfunction

endpackage

// File: rtl/fazyrv_rf_word.sv
// One register stored LSB-first as a chunk-wide shift register with a parallel read port.
module fazyrv_rf_word
  import fazyrv_rf_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned CHUNKSIZE = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic                 shft_i,
  input  logic [CHUNKSIZE-1:0] din_i,
  output logic [CHUNKSIZE-1:0] dout_o,
  output logic [XLEN-1:0]      word_o
);

  logic [XLEN-1:0] word_q, word_d;

  // New data enters at the top; the low chunk is always the one on the output.
  always_comb begin
    word_d = word_q;
    if (shft_i) begin
      word_d = {din_i, word_q[XLEN-1:CHUNKSIZE]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign dout_o = word_q[CHUNKSIZE-1:0];
  assign word_o = word_q;

endmodule

// File: rtl/fazyrv_rf_lut_gated.sv
// Logic-based register file: only registers named by the latched rs1/rs2/rd rotate,
// a rotation FSM enforces whole-word rotations, and an idle debug port reads full words.
module fazyrv_rf_lut_gated
  import fazyrv_rf_pkg::*;
#(
  parameter int unsigned CHUNKSIZE = 2,
  parameter int unsigned NR_REGS   = 32,
  parameter int unsigned XLEN      = XLEN_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic                 start_i,
  input  logic                 shft_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [4:0]           rd_i,
  input  logic                 we_i,
  input  logic [CHUNKSIZE-1:0] res_i,
  output logic [CHUNKSIZE-1:0] ra_o,
  output logic [CHUNKSIZE-1:0] rb_o,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 dbg_req_i,
  input  logic [4:0]           dbg_addr_i,
  output logic                 dbg_ack_o,
  output logic [XLEN-1:0]      dbg_dat_o
);

  localparam int unsigned NCHUNK = nchunk(XLEN, CHUNKSIZE);
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  rf_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic             done_q, done_d;
  logic             ack_q, ack_d;
  logic [XLEN-1:0]  dbg_dat_q, dbg_dat_d;

  logic [CHUNKSIZE-1:0] dout  [NR_REGS];
  logic [XLEN-1:0]      words [NR_REGS];
  logic                 rot_shift;
  logic [4:0]           ra_sel, rb_sel;
  logic [XLEN-1:0]      dbg_word;

  assign rot_shift = (state_q == RF_ROT) && shft_i;

  // x0 has no storage and reads as zero.
  assign dout[0]  = '0;
  assign words[0] = '0;

  for (genvar i = 1; i < NR_REGS; i++) begin : g_reg
    localparam logic [4:0] Addr = 5'(i);
    logic hit, wsel, shft;
    logic [CHUNKSIZE-1:0] din;

    // A register named by several operands still shifts only once per step.
    assign hit  = (rs1_q == Addr) || (rs2_q == Addr) || (rd_q == Addr);
    assign wsel = we_i && (rd_q == Addr);
    assign shft = rot_shift && hit;
    assign din  = wsel ? res_i : dout[i];

    fazyrv_rf_word #(
      .XLEN      (XLEN),
      .CHUNKSIZE (CHUNKSIZE)
    ) u_word (
      .clk_i  (clk_i),
      .rst_in (rst_in),
      .shft_i (shft),
      .din_i  (din),
      .dout_o (dout[i]),
      .word_o (words[i])
    );
  end

  // Operand read muxes; addresses beyond NR_REGS match nothing and read zero.
  always_comb begin
    ra_sel   = (state_q == RF_IDLE) ? rs1_i : rs1_q;
    rb_sel   = (state_q == RF_IDLE) ? rs2_i : rs2_q;
    ra_o     = '0;
    rb_o     = '0;
    dbg_word = '0;
    for (int i = 0; i < int'(NR_REGS); i++) begin
      if (ra_sel == 5'(i)) ra_o = dout[i];
      if (rb_sel == 5'(i)) rb_o = dout[i];
      if (dbg_addr_i == 5'(i)) dbg_word = words[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    done_d    = 1'b0;
    ack_d     = 1'b0;
    dbg_dat_d = dbg_dat_q;
    unique case (state_q)
      RF_IDLE: begin
        // start wins over a simultaneous debug request.
        if (start_i) begin
          rs1_d   = rs1_i;
          rs2_d   = rs2_i;
          rd_d    = rd_i;
          cnt_d   = '0;
          state_d = RF_ROT;
        end else if (dbg_req_i) begin
          ack_d     = 1'b1;
          dbg_dat_d = dbg_word;
        end
      end
      RF_ROT: begin
        if (shft_i) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = RF_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= RF_IDLE;
      cnt_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      dbg_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      dbg_dat_q <= dbg_dat_d;
    end
  end

  assign busy_o    = (state_q == RF_ROT);
  assign done_o    = done_q;
  assign dbg_ack_o = ack_q;
  assign dbg_dat_o = dbg_dat_q;

endmodule

// File: tb/tb_fazyrv_rf_lut_gated.sv
// Directed bench: a 32-register and a 16-register (RVE) instance share one stimulus stream.
module tb_fazyrv_rf_lut_gated;

  logic        clk, rst_n, start, shft, we, dbg_req;
  logic [4:0]  rs1, rs2, rd, dbg_addr;
  logic [1:0]  res;
  logic [1:0]  ra, rb, e_ra, e_rb;
  logic        busy, done, ack, e_busy, e_done, e_ack;
  logic [31:0] dat, e_dat;

  int errors = 0;
  int checks = 0;
  int sh7 = 0;
  int sh9 = 0;

  fazyrv_rf_lut_gated #(.CHUNKSIZE(2), .NR_REGS(32), .XLEN(32)) dut (
    .clk_i(clk), .rst_in(rst_n), .start_i(start), .shft_i(shft), .rs1_i(rs1), .rs2_i(rs2),
    .rd_i(rd), .we_i(we), .res_i(res), .ra_o(ra), .rb_o(rb), .busy_o(busy), .done_o(done),
    .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_ack_o(ack), .dbg_dat_o(dat)
  );

  fazyrv_rf_lut_gated #(.CHUNKSIZE(2), .NR_REGS(16), .XLEN(32)) dut_rve (
    .clk_i(clk), .rst_in(rst_n), .start_i(start), .shft_i(shft), .rs1_i(rs1), .rs2_i(rs2),
    .rd_i(rd), .we_i(we), .res_i(res), .ra_o(e_ra), .rb_o(e_rb), .busy_o(e_busy),
    .done_o(e_done), .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_ack_o(e_ack),
    .dbg_dat_o(e_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.g_reg[7].u_word.shft_i) sh7 <= sh7 + 1;
    if (dut.g_reg[9].u_word.shft_i) sh9 <= sh9 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full rotation; inc=1 feeds res = ra + 1 as a serial chunk adder.
  task automatic rotate(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                        input logic w, input logic [31:0] data, input bit inc,
                        output logic [31:0] wa, output logic [31:0] wb,
                        output logic [31:0] ewa, output logic [31:0] ewb,
                        output int ndiff, output bit done_ok);
    logic       carry;
    logic [2:0] sum;
    bit         early;
    rs1 = a1; rs2 = a2; rd = d; start = 1'b1;
    tick();
    start = 1'b0;
    carry = 1'b1; early = 1'b0; ndiff = 0;
    wa = '0; wb = '0; ewa = '0; ewb = '0;
    for (int k = 0; k < 16; k++) begin
      shft = 1'b1;
      we   = w;
      res  = data[2*k +: 2];
      @(negedge clk);
      wa[2*k +: 2]  = ra;
      wb[2*k +: 2]  = rb;
      ewa[2*k +: 2] = e_ra;
      ewb[2*k +: 2] = e_rb;
      if (ra !== rb) ndiff++;
      if (done || !busy) early = 1'b1;
      if (inc) begin
        sum   = {1'b0, ra} + {2'b00, carry};
        res   = sum[1:0];
        carry = sum[2];
      end
      tick();
    end
    shft = 1'b0;
    we   = 1'b0;
    done_ok = done && !busy && !early;
    tick();
    done_ok = done_ok && !done;
  endtask

  task automatic dbg_read(input logic [4:0] addr, output logic [31:0] d, output logic [31:0] ed,
                          output logic a, output logic ea);
    dbg_req  = 1'b1;
    dbg_addr = addr;
    tick();
    dbg_req = 1'b0;
    a  = ack;
    ea = e_ack;
    d  = dat;
    ed = e_dat;
  endtask

  logic [31:0] wa, wb, ewa, ewb, d, ed;
  logic        a, ea;
  int          nd, s0;
  bit          ok, early_ack;

  initial begin
    rst_n = 1'b0; start = 1'b0; shft = 1'b0; we = 1'b0; dbg_req = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; dbg_addr = '0; res = '0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", dat, 32'h0);
    rst_n = 1'b1;
    tick();

    // Write x5, then reset in the middle of a rotation over it.
    rotate(5'd0, 5'd0, 5'd5, 1'b1, 32'hA5A5A5A5, 1'b0, wa, wb, ewa, ewb, nd, ok);
    check("w5_done", 32'(ok), 32'd1);
    dbg_read(5'd5, d, ed, a, ea);
    check("x5_ack", 32'(a), 32'd1);
    check("x5_pre", d, 32'hA5A5A5A5);
    rs1 = 5'd5; rs2 = 5'd5; rd = 5'd5; start = 1'b1;
    tick();
    start = 1'b0; shft = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    rst_n = 1'b0;
    shft  = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dat", dat, 32'h0);
    dbg_read(5'd5, d, ed, a, ea);
    check("midrst_x5", d, 32'h0);

    // Write x3 and read it back serially through both ports.
    rotate(5'd0, 5'd0, 5'd3, 1'b1, 32'hDEADBEEF, 1'b0, wa, wb, ewa, ewb, nd, ok);
    check("w3_done", 32'(ok), 32'd1);
    rotate(5'd3, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, wa, wb, ewa, ewb, nd, ok);
    check("r3_done", 32'(ok), 32'd1);
    check("r3_ra", wa, 32'hDEADBEEF);
    check("r3_rb_x0", wb, 32'h0);
    check("r3_rve_ra", ewa, 32'hDEADBEEF);

    // IDLE: combinational read of rs1_i; shft/we ignored.
    rs1 = 5'd3; rs2 = 5'd0; rd = 5'd3; shft = 1'b1; we = 1'b1; res = 2'b00;
    #1;
    check("idle_ra", 32'(ra), 32'd3);
    repeat (3) tick();
    shft = 1'b0; we = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    dbg_read(5'd3, d, ed, a, ea);
    check("idle_x3", d, 32'hDEADBEEF);

    // Self-modifying x7: 1 -> 2 with rs1 = rs2 = rd = x7.
    rotate(5'd0, 5'd0, 5'd7, 1'b1, 32'h1, 1'b0, wa, wb, ewa, ewb, nd, ok);
    s0 = sh7;
    rotate(5'd7, 5'd7, 5'd7, 1'b1, 32'h0, 1'b1, wa, wb, ewa, ewb, nd, ok);
    check("inc_done", 32'(ok), 32'd1);
    check("inc_ra_eq_rb", 32'(nd), 32'd0);
    check("inc_old", wa, 32'h1);
    check("x7_shifts", 32'(sh7 - s0), 32'd16);
    dbg_read(5'd7, d, ed, a, ea);
    check("x7_val", d, 32'h2);

    // Gating: x9 must not move during a rotation on x1/x2/x4.
    rotate(5'd0, 5'd0, 5'd9, 1'b1, 32'h12345678, 1'b0, wa, wb, ewa, ewb, nd, ok);
    s0 = sh9;
    rotate(5'd1, 5'd2, 5'd4, 1'b1, 32'h0000CAFE, 1'b0, wa, wb, ewa, ewb, nd, ok);
    check("x9_shifts", 32'(sh9 - s0), 32'd0);
    dbg_read(5'd9, d, ed, a, ea);
    check("x9_val", d, 32'h12345678);
    dbg_read(5'd4, d, ed, a, ea);
    check("x4_val", d, 32'h0000CAFE);
    check("rve_x4_val", ed, 32'h0000CAFE);

    // RVE: x20 does not exist in the 16-register instance.
    rotate(5'd0, 5'd0, 5'd20, 1'b1, 32'hFFFFFFFF, 1'b0, wa, wb, ewa, ewb, nd, ok);
    dbg_read(5'd20, d, ed, a, ea);
    check("x20_val", d, 32'hFFFFFFFF);
    check("rve_x20_val", ed, 32'h0);
    check("rve_x20_ack", 32'(ea), 32'd1);
    rotate(5'd20, 5'd4, 5'd0, 1'b0, 32'h0, 1'b0, wa, wb, ewa, ewb, nd, ok);
    check("x20_ra", wa, 32'hFFFFFFFF);
    check("rve_x20_ra", ewa, 32'h0);
    check("rve_x4_rb", ewb, 32'h0000CAFE);

    // Writes to x0 are dropped.
    rotate(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF, 1'b0, wa, wb, ewa, ewb, nd, ok);
    dbg_read(5'd0, d, ed, a, ea);
    check("x0_val", d, 32'h0);

    // start and dbg_req together: rotation first, ack the cycle after done.
    rs1 = 5'd9; rs2 = 5'd9; rd = 5'd9; we = 1'b0;
    start = 1'b1; dbg_req = 1'b1; dbg_addr = 5'd9;
    tick();
    start = 1'b0;
    check("cont_busy", 32'(busy), 32'd1);
    early_ack = ack;
    for (int k = 0; k < 16; k++) begin
      shft = 1'b1;
      tick();
      if (k < 15) early_ack = early_ack | ack;
    end
    shft = 1'b0;
    check("cont_no_ack", 32'(early_ack), 32'd0);
    check("cont_done", 32'(done), 32'd1);
    check("cont_ack_vs_done", 32'(ack), 32'd0);
    tick();
    dbg_req = 1'b0;
    check("cont_ack", 32'(ack), 32'd1);
    check("cont_dat", dat, 32'h12345678);
    check("cont_done_off", 32'(done), 32'd0);
    tick();
    check("ack_pulse", 32'(ack), 32'd0);
    check("dat_hold", dat, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
